// File: rtl/wave_pkg.sv
// ----------------------------------------------------------------------------
// wave_pkg
//   Shared definitions for the oscilloscope waveform capture path:
//   default geometry of the wave RAM record, the sequencer state encodings
//   and the trigger comparison used by the trigger detector.
//   No ports (package).
// ----------------------------------------------------------------------------
package wave_pkg;

    localparam int DEPTH_DEF       = 300;
    localparam int ADDR_W_DEF      = 9;
    localparam int PRE_TRIG_DEF    = 150;
    localparam int HOLD_FRAMES_DEF = 2;
    localparam int TIMEOUT_DEF     = 4096;

    localparam int STATE_W = 3;

    // Kept as plain constants so the status display can decode them directly.
    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRE_FILL = 3'd1;
    localparam logic [STATE_W-1:0] ST_ARMED    = 3'd2;
    localparam logic [STATE_W-1:0] ST_POST     = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD     = 3'd4;

    // Level crossing between two consecutive samples; falling selects the
    // direction of the crossing.
    function automatic logic edge_cross(input logic [7:0] prev,
                                        input logic [7:0] cur,
                                        input logic [7:0] level,
                                        input logic       falling);
        if (falling) begin
            return (prev > level) && (cur <= level);
        end
        return (prev < level) && (cur >= level);
    endfunction

endpackage

// File: rtl/wave_trig_detect.sv
// ----------------------------------------------------------------------------
// wave_trig_detect
//   Remembers the previously accepted sample and flags when the current
//   accepted sample crosses the trigger level in the selected direction.
//   Ports:
//     clk_i          clock
//     rst_n_i        asynchronous active-low reset
//     clear_i        forget the previous sample (start of a new record)
//     sample_valid_i current sample is an accepted sample
//     sample_i       current sample
//     level_i        trigger threshold
//     edge_i         0 rising, 1 falling
//     hit_o          combinational: current accepted sample is a trigger
// ----------------------------------------------------------------------------
module wave_trig_detect
    import wave_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clear_i,
    input  logic       sample_valid_i,
    input  logic [7:0] sample_i,
    input  logic [7:0] level_i,
    input  logic       edge_i,
    output logic       hit_o
);

    logic [7:0] prev_q;
    logic       prev_valid_q;

    // The valid flag keeps the very first sample of a record from being
    // compared against a stale or reset value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (clear_i) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (sample_valid_i) begin
            prev_q       <= sample_i;
            prev_valid_q <= 1'b1;
        end
    end

    assign hit_o = sample_valid_i && prev_valid_q &&
                   edge_cross(prev_q, sample_i, level_i, edge_i);

endmodule

// File: rtl/wave_capture_ctrl.sv
// ----------------------------------------------------------------------------
// wave_capture_ctrl
//   Waveform capture sequencer. Writes decimated AD samples into a circular
//   DEPTH-entry wave RAM around a trigger, freezes the RAM in HOLD and
//   translates renderer column requests (with horizontal shift) into RAM
//   read addresses. Re-arms after HOLD_FRAMES renderer frames.
//   Ports:
//     lcd_clk_i      clock                sys_rst_n_i   async active-low reset
//     ad_valid_i     sample strobe        ad_data_i     sample value
//     trig_level_i   trigger threshold    trig_edge_i   0 rising / 1 falling
//     decim_i        keep 1 of decim+1    run_i         continuous acquisition
//     single_i       single capture pulse h_shift_i     [9] dir, [8:0] offset
//     data_req_i     renderer read req    line_cnt_i    renderer column
//     wr_over_i      frame-complete pulse
//     ram_wr_en_o/ram_wr_addr_o/ram_wr_data_o   RAM write port (registered)
//     ram_rd_addr_o  RAM read address     outrange_o    column has no sample
//     trig_found_o   1 triggered, 0 auto  state_o       FSM state
// ----------------------------------------------------------------------------
module wave_capture_ctrl
    import wave_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int PRE_TRIG    = PRE_TRIG_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic               lcd_clk_i,
    input  logic               sys_rst_n_i,
    input  logic               ad_valid_i,
    input  logic [7:0]         ad_data_i,
    input  logic [7:0]         trig_level_i,
    input  logic               trig_edge_i,
    input  logic [3:0]         decim_i,
    input  logic               run_i,
    input  logic               single_i,
    input  logic [ADDR_W:0]    h_shift_i,
    input  logic               data_req_i,
    input  logic [ADDR_W-1:0]  line_cnt_i,
    input  logic               wr_over_i,
    output logic               ram_wr_en_o,
    output logic [ADDR_W-1:0]  ram_wr_addr_o,
    output logic [7:0]         ram_wr_data_o,
    output logic [ADDR_W-1:0]  ram_rd_addr_o,
    output logic               outrange_o,
    output logic               trig_found_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_W    = $clog2(TIMEOUT + 1);
    localparam int IDX_W    = ADDR_W + 2;
    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_ADDR    = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] PRE_COMPL   = ADDR_W'(DEPTH - PRE_TRIG);
    localparam logic [ADDR_W:0]   DEPTH_SUM   = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  DEPTH_IDX   = IDX_W'(DEPTH);
    localparam logic [CNT_W-1:0]  PRE_LAST    = CNT_W'(PRE_TRIG - 1);
    localparam logic [CNT_W-1:0]  TO_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  POST_LAST   = CNT_W'(POST_LEN - 1);
    localparam logic [CNT_W-1:0]  FRAMES_LAST = CNT_W'(HOLD_FRAMES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               single_mode_q, single_mode_d;
    logic [ADDR_W-1:0]  trig_addr_q, trig_addr_d;
    logic               trig_found_q, trig_found_d;
    logic [3:0]         decim_q, decim_d;
    logic [3:0]         dcnt_q, dcnt_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic               wr_over_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [7:0]         wr_data_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic               outrange_q;

    logic writing, abort, strobe, accept, hit, restart, wr_rise;

    // A single-shot capture must survive run being low, so only a
    // run-mode record is aborted by dropping run.
    assign writing = (state_q == ST_PRE_FILL) || (state_q == ST_ARMED) ||
                     (state_q == ST_POST);
    assign abort   = ((state_q == ST_PRE_FILL) || (state_q == ST_ARMED)) &&
                     !run_i && !single_mode_q;
    assign strobe  = ad_valid_i && writing && !abort;
    assign accept  = strobe && (dcnt_q == 4'd0);
    assign wr_rise = wr_over_i && !wr_over_q;

    wave_trig_detect u_trig (
        .clk_i          (lcd_clk_i),
        .rst_n_i        (sys_rst_n_i),
        .clear_i        (restart),
        .sample_valid_i (accept),
        .sample_i       (ad_data_i),
        .level_i        (trig_level_i),
        .edge_i         (trig_edge_i),
        .hit_o          (hit)
    );

    // Next-state logic. cnt_q is shared: samples in PRE_FILL/ARMED/POST,
    // frames in HOLD; it is cleared on every state change.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        single_mode_d = single_mode_q;
        trig_addr_d   = trig_addr_q;
        trig_found_d  = trig_found_q;
        decim_d       = decim_q;
        dcnt_d        = dcnt_q;
        wr_ptr_d      = wr_ptr_q;
        restart       = 1'b0;

        if (strobe) begin
            dcnt_d = (dcnt_q == 4'd0) ? decim_q : dcnt_q - 4'd1;
        end
        if (accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        end
        if ((state_q != ST_IDLE) && single_i) begin
            single_mode_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (single_i || run_i) begin
                    restart       = 1'b1;
                    single_mode_d = single_i;
                end
            end
            ST_PRE_FILL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (hit || (cnt_q == TO_LAST)) begin
                        state_d      = ST_POST;
                        cnt_d        = '0;
                        trig_addr_d  = wr_ptr_q;
                        trig_found_d = hit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_POST: begin
                if (accept) begin
                    if (cnt_q == POST_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (wr_rise) begin
                    if (cnt_q == FRAMES_LAST) begin
                        cnt_d = '0;
                        if (run_i && !single_mode_q) begin
                            restart = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Starting a record latches the decimation setting and restarts
        // the decimation phase so the first strobe is kept.
        if (restart) begin
            state_d = ST_PRE_FILL;
            cnt_d   = '0;
            decim_d = decim_i;
            dcnt_d  = 4'd0;
        end
    end

    // Read path: shifted column index, then map it into the frozen record
    // that starts PRE_TRIG entries before the trigger address.
    logic [IDX_W-1:0]  line_ext, amt_ext, idx;
    logic              idx_in_range, rd_valid;
    logic [ADDR_W-1:0] rd_base, rd_next;
    logic [ADDR_W:0]   rd_sum;

    assign line_ext     = {2'b00, line_cnt_i};
    assign amt_ext      = {2'b00, h_shift_i[ADDR_W-1:0]};
    assign idx          = h_shift_i[ADDR_W] ? (line_ext - amt_ext)
                                            : (line_ext + amt_ext);
    assign idx_in_range = !idx[IDX_W-1] && (idx < DEPTH_IDX);
    assign rd_base      = (trig_addr_q >= PRE_ADDR) ? (trig_addr_q - PRE_ADDR)
                                                    : (trig_addr_q + PRE_COMPL);
    assign rd_sum       = {1'b0, rd_base} + {1'b0, idx[ADDR_W-1:0]};
    assign rd_next      = (rd_sum >= DEPTH_SUM) ? ADDR_W'(rd_sum - DEPTH_SUM)
                                                : rd_sum[ADDR_W-1:0];
    assign rd_valid     = (state_q == ST_HOLD) && data_req_i && idx_in_range;

    // All sequencer, write-port and read-port registers.
    always_ff @(posedge lcd_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            single_mode_q <= 1'b0;
            trig_addr_q   <= '0;
            trig_found_q  <= 1'b0;
            decim_q       <= 4'd0;
            dcnt_q        <= 4'd0;
            wr_ptr_q      <= '0;
            wr_over_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_addr_q     <= '0;
            outrange_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            single_mode_q <= single_mode_d;
            trig_addr_q   <= trig_addr_d;
            trig_found_q  <= trig_found_d;
            decim_q       <= decim_d;
            dcnt_q        <= dcnt_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_over_q     <= wr_over_i;
            wr_en_q       <= accept;
            if (accept) begin
                wr_addr_q <= wr_ptr_q;
                wr_data_q <= ad_data_i;
            end
            rd_addr_q     <= rd_valid ? rd_next : '0;
            outrange_q    <= !rd_valid;
        end
    end

    assign ram_wr_en_o   = wr_en_q;
    assign ram_wr_addr_o = wr_addr_q;
    assign ram_wr_data_o = wr_data_q;
    assign ram_rd_addr_o = rd_addr_q;
    // Masked with the live state so the flag never lags a HOLD exit.
    assign outrange_o    = outrange_q || (state_q != ST_HOLD);
    assign trig_found_o  = trig_found_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_wave_capture_ctrl
//   Directed bench for the waveform capture sequencer. Models the external
//   wave RAM from the write port and checks hand-computed addresses/values.
// ----------------------------------------------------------------------------
module tb_wave_capture_ctrl;
    import wave_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ad_valid, trig_edge, run, single, data_req, wr_over;
    logic [7:0] ad_data, trig_level;
    logic [3:0] decim;
    logic [9:0] h_shift;
    logic [8:0] line_cnt;
    logic       ram_wr_en, outrange, trig_found;
    logic [8:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] ram_wr_data;
    logic [2:0] state;

    int checks = 0;
    int fails  = 0;
    int wr_count = 0;
    int ramp_k = 0;
    logic [7:0] ram [0:511];

    wave_capture_ctrl dut (
        .lcd_clk_i     (clk),
        .sys_rst_n_i   (rst_n),
        .ad_valid_i    (ad_valid),
        .ad_data_i     (ad_data),
        .trig_level_i  (trig_level),
        .trig_edge_i   (trig_edge),
        .decim_i       (decim),
        .run_i         (run),
        .single_i      (single),
        .h_shift_i     (h_shift),
        .data_req_i    (data_req),
        .line_cnt_i    (line_cnt),
        .wr_over_i     (wr_over),
        .ram_wr_en_o   (ram_wr_en),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_wr_data_o (ram_wr_data),
        .ram_rd_addr_o (ram_rd_addr),
        .outrange_o    (outrange),
        .trig_found_o  (trig_found),
        .state_o       (state)
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

    // External wave RAM model plus a running count of write strobes.
    always @(posedge clk) begin
        if (ram_wr_en) begin
            ram[ram_wr_addr] <= ram_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed one strobe per cycle until the FSM reports target or the budget
    // runs out; n is the number of strobes fed before target was seen.
    task automatic feed_until(input logic [2:0] target, input bit ramp,
                              input logic [7:0] cval, input int budget,
                              output int n, output bit reached);
        reached = 1'b0;
        n = 0;
        while (n < budget && state !== target) begin
            ad_valid = 1'b1;
            ad_data  = ramp ? 8'(ramp_k) : cval;
            ramp_k++;
            tick();
            n++;
        end
        reached  = (state === target);
        ad_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (state !== ST_IDLE) begin fails++; $display("[TB] FAIL reset_state: got %0d expected %0d", state, ST_IDLE); end
        checks++; if (outrange !== 1'b1) begin fails++; $display("[TB] FAIL reset_outrange: got %0b expected 1", outrange); end
        checks++; if (ram_wr_en !== 1'b0 || ram_wr_addr !== 9'd0 || ram_wr_data !== 8'd0) begin fails++; $display("[TB] FAIL reset_wr_port: got en=%0b addr=%0d data=%0d expected 0/0/0", ram_wr_en, ram_wr_addr, ram_wr_data); end
        checks++; if (ram_rd_addr !== 9'd0 || trig_found !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_trig: got rd=%0d tf=%0b expected 0/0", ram_rd_addr, trig_found); end
    endtask

    task automatic test_ramp_single();
        int n; bit ok; int s0;
        single = 1'b1; tick(); single = 1'b0;
        checks++; if (state !== ST_PRE_FILL) begin fails++; $display("[TB] FAIL single_start: got %0d expected %0d", state, ST_PRE_FILL); end
        s0 = wr_count;
        ramp_k = 0;
        feed_until(ST_HOLD, 1'b1, 8'd0, 1000, n, ok);
        checks++; if (!ok || n != 534) begin fails++; $display("[TB] FAIL ramp_len: got %0d strobes (reached=%0b) expected 534", n, ok); end
        tick(); tick();
        checks++; if (wr_count - s0 != 534) begin fails++; $display("[TB] FAIL ramp_writes: got %0d expected 534", wr_count - s0); end
        checks++; if (trig_found !== 1'b1) begin fails++; $display("[TB] FAIL ramp_trig_found: got %0b expected 1", trig_found); end
        data_req = 1'b1; h_shift = 10'h000;
        line_cnt = 9'd150; tick();
        checks++; if (ram_rd_addr !== 9'd84 || outrange !== 1'b0) begin fails++; $display("[TB] FAIL col150_addr: got %0d/or=%0b expected 84/0", ram_rd_addr, outrange); end
        checks++; if (ram[ram_rd_addr] !== 8'd128) begin fails++; $display("[TB] FAIL col150_data: got %0d expected 128", ram[ram_rd_addr]); end
        line_cnt = 9'd0; tick();
        checks++; if (ram_rd_addr !== 9'd234 || ram[ram_rd_addr] !== 8'd234) begin fails++; $display("[TB] FAIL col0: got addr %0d data %0d expected 234/234", ram_rd_addr, ram[ram_rd_addr]); end
        line_cnt = 9'd299; tick();
        checks++; if (ram_rd_addr !== 9'd233 || ram[ram_rd_addr] !== 8'd21) begin fails++; $display("[TB] FAIL col299: got addr %0d data %0d expected 233/21", ram_rd_addr, ram[ram_rd_addr]); end
    endtask

    task automatic test_hshift();
        h_shift = 10'h00A;
        line_cnt = 9'd289; tick();
        checks++; if (ram_rd_addr !== 9'd233 || outrange !== 1'b0) begin fails++; $display("[TB] FAIL left_289: got %0d/or=%0b expected 233/0", ram_rd_addr, outrange); end
        line_cnt = 9'd290; tick();
        checks++; if (ram_rd_addr !== 9'd0 || outrange !== 1'b1) begin fails++; $display("[TB] FAIL left_290: got %0d/or=%0b expected 0/1", ram_rd_addr, outrange); end
        line_cnt = 9'd299; tick();
        checks++; if (outrange !== 1'b1) begin fails++; $display("[TB] FAIL left_299: got or=%0b expected 1", outrange); end
        line_cnt = 9'd0; tick();
        checks++; if (ram_rd_addr !== 9'd244 || outrange !== 1'b0) begin fails++; $display("[TB] FAIL left_0: got %0d/or=%0b expected 244/0", ram_rd_addr, outrange); end
        h_shift = 10'h205;
        line_cnt = 9'd4; tick();
        checks++; if (ram_rd_addr !== 9'd0 || outrange !== 1'b1) begin fails++; $display("[TB] FAIL right_4: got %0d/or=%0b expected 0/1", ram_rd_addr, outrange); end
        line_cnt = 9'd5; tick();
        checks++; if (ram_rd_addr !== 9'd234 || outrange !== 1'b0) begin fails++; $display("[TB] FAIL right_5: got %0d/or=%0b expected 234/0", ram_rd_addr, outrange); end
        data_req = 1'b0; h_shift = 10'h000; line_cnt = 9'd150; tick();
        checks++; if (ram_rd_addr !== 9'd0 || outrange !== 1'b1) begin fails++; $display("[TB] FAIL no_req: got %0d/or=%0b expected 0/1", ram_rd_addr, outrange); end
    endtask

    task automatic test_hold_frames_single();
        ad_valid = 1'b1; ad_data = 8'd77; wr_over = 1'b1; tick();
        ad_valid = 1'b0; wr_over = 1'b0;
        checks++; if (state !== ST_HOLD || ram_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL hold_frame1: got state %0d wr_en %0b expected %0d/0", state, ram_wr_en, ST_HOLD); end
        tick();
        wr_over = 1'b1; tick(); wr_over = 1'b0;
        checks++; if (state !== ST_IDLE) begin fails++; $display("[TB] FAIL hold_frame2_idle: got %0d expected %0d", state, ST_IDLE); end
        data_req = 1'b1; line_cnt = 9'd10; tick();
        checks++; if (outrange !== 1'b1) begin fails++; $display("[TB] FAIL idle_outrange: got %0b expected 1", outrange); end
        data_req = 1'b0;
    endtask

    task automatic test_decim_abort();
        int n; bit ok; int s0;
        decim = 4'd3; run = 1'b1; tick();
        checks++; if (state !== ST_PRE_FILL) begin fails++; $display("[TB] FAIL run_start: got %0d expected %0d", state, ST_PRE_FILL); end
        s0 = wr_count;
        for (int i = 0; i < 40; i++) begin
            ad_valid = 1'b1; ad_data = 8'd50; tick();
            if (i == 0) begin
                checks++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 9'd234) begin fails++; $display("[TB] FAIL decim_first: got en=%0b addr=%0d expected 1/234", ram_wr_en, ram_wr_addr); end
            end
            if (i == 1) begin
                checks++; if (ram_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL decim_skip: got %0b expected 0", ram_wr_en); end
            end
        end
        ad_valid = 1'b0; tick(); tick();
        checks++; if (wr_count - s0 != 10) begin fails++; $display("[TB] FAIL decim_ratio: got %0d writes expected 10", wr_count - s0); end
        feed_until(ST_ARMED, 1'b0, 8'd50, 1000, n, ok);
        checks++; if (!ok || n != 557) begin fails++; $display("[TB] FAIL decim_prefill: got %0d strobes (reached=%0b) expected 557", n, ok); end
        for (int i = 0; i < 3; i++) begin ad_valid = 1'b1; tick(); end
        run = 1'b0; tick();
        checks++; if (state !== ST_IDLE || ram_wr_en !== 1'b0) begin fails++; $display("[TB] FAIL abort: got state %0d wr_en %0b expected %0d/0", state, ram_wr_en, ST_IDLE); end
        s0 = wr_count;
        for (int i = 0; i < 20; i++) tick();
        ad_valid = 1'b0; tick();
        checks++; if (wr_count != s0 || state !== ST_IDLE) begin fails++; $display("[TB] FAIL abort_quiet: got %0d writes state %0d expected 0/%0d", wr_count - s0, state, ST_IDLE); end
    endtask

    task automatic test_timeout();
        int n; bit ok;
        decim = 4'd0; run = 1'b1; tick();
        feed_until(ST_ARMED, 1'b0, 8'd50, 200, n, ok);
        checks++; if (!ok || n != 150) begin fails++; $display("[TB] FAIL to_prefill: got %0d (reached=%0b) expected 150", n, ok); end
        feed_until(ST_POST, 1'b0, 8'd50, 5000, n, ok);
        checks++; if (!ok || n != 4096) begin fails++; $display("[TB] FAIL to_count: got %0d (reached=%0b) expected 4096", n, ok); end
        checks++; if (trig_found !== 1'b0) begin fails++; $display("[TB] FAIL to_trig_found: got %0b expected 0", trig_found); end
    endtask

    task automatic test_reset_mid_post();
        ad_valid = 1'b1; ad_data = 8'd50;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (state !== ST_POST || ram_wr_en !== 1'b1) begin fails++; $display("[TB] FAIL post_active: got state %0d wr_en %0b expected %0d/1", state, ram_wr_en, ST_POST); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== ST_IDLE || outrange !== 1'b1 || trig_found !== 1'b0) begin fails++; $display("[TB] FAIL midreset_ctl: got state %0d or %0b tf %0b expected 0/1/0", state, outrange, trig_found); end
        checks++; if (ram_wr_en !== 1'b0 || ram_wr_addr !== 9'd0 || ram_wr_data !== 8'd0 || ram_rd_addr !== 9'd0) begin fails++; $display("[TB] FAIL midreset_ports: got en %0b wa %0d wd %0d ra %0d expected 0/0/0/0", ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr); end
        ad_valid = 1'b0; run = 1'b0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rearm();
        int n; bit ok;
        decim = 4'd0; run = 1'b1; tick();
        ramp_k = 0;
        feed_until(ST_HOLD, 1'b1, 8'd0, 1000, n, ok);
        checks++; if (!ok || n != 534 || trig_found !== 1'b1) begin fails++; $display("[TB] FAIL rearm_rec: got %0d strobes tf %0b (reached=%0b) expected 534/1", n, trig_found, ok); end
        data_req = 1'b1; line_cnt = 9'd150; tick(); data_req = 1'b0;
        checks++; if (ram_rd_addr !== 9'd84) begin fails++; $display("[TB] FAIL rearm_trig_addr: got %0d expected 84", ram_rd_addr); end
        wr_over = 1'b1; tick(); wr_over = 1'b0;
        checks++; if (state !== ST_HOLD) begin fails++; $display("[TB] FAIL rearm_frame1: got %0d expected %0d", state, ST_HOLD); end
        tick();
        wr_over = 1'b1; tick(); wr_over = 1'b0;
        checks++; if (state !== ST_PRE_FILL) begin fails++; $display("[TB] FAIL rearm_frame2: got %0d expected %0d", state, ST_PRE_FILL); end
        single = 1'b1; tick(); single = 1'b0;
        ramp_k = 0;
        feed_until(ST_HOLD, 1'b1, 8'd0, 1000, n, ok);
        checks++; if (!ok || n != 534) begin fails++; $display("[TB] FAIL single_mode_rec: got %0d (reached=%0b) expected 534", n, ok); end
        wr_over = 1'b1; tick(); wr_over = 1'b0; tick();
        wr_over = 1'b1; tick(); wr_over = 1'b0;
        checks++; if (state !== ST_IDLE) begin fails++; $display("[TB] FAIL single_mode_noarm: got %0d expected %0d", state, ST_IDLE); end
        run = 1'b0; tick();
    endtask

    // Overall time limit so a stuck FSM still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Scenario sequence.
    initial begin
        rst_n = 1'b0; ad_valid = 1'b0; ad_data = 8'd0; trig_level = 8'd128;
        trig_edge = 1'b0; decim = 4'd0; run = 1'b0; single = 1'b0;
        h_shift = 10'h000; data_req = 1'b0; line_cnt = 9'd0; wr_over = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_ramp_single();
        test_hshift();
        test_hold_frames_single();
        test_decim_abort();
        test_timeout();
        test_reset_mid_post();
        test_rearm();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
